pixel_fetch: RTL and testbench
==============================

PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameter SRAM_WAIT, default 1, SHALL set the number of cycles from SRAM address/OE assertion to data capture (legal 1..7).
REQ-002 Parameter BUF_DEPTH, default 4, SHALL set the pixel output buffer depth (power of two, 2..16).
REQ-003 Parameter BORDER_COLOUR, default 16'h001F, SHALL set the colour emitted for invalid addresses when PIXEL_FETCH_BORDER_EN is defined.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RESET_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 iADDRESS  input  20  SHALL carry the address FIFO word: bit 19 = valid, bits 18:0 = pixel address.
REQ-007 iREADY_N  input  1  SHALL be the address FIFO empty flag (low = word available).
REQ-008 oREAD  output  1  SHALL be the address FIFO read request, one cycle per word.
REQ-009 oSRAM_ADDR  output  20  SHALL carry the SRAM word address, zero-extended from bits 18:0.
REQ-010 oSRAM_OE_N  output  1  SHALL be the active-low SRAM output enable.
REQ-011 iSRAM_DQ  input  16  SHALL carry SRAM read data.
REQ-012 iDISP_REQ  input  1  SHALL request one pixel from the buffer.
REQ-013 oPIXEL  output  16  SHALL present the buffer head pixel (show-ahead).
REQ-014 oPIXEL_VALID  output  1  SHALL be high when the buffer is non-empty.
REQ-015 oUNDERRUN  output  1  SHALL be a sticky flag for display requests made while the buffer is empty.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_Q, READ.
REQ-017 In IDLE, if iREADY_N=0 and (buffer count + in-flight) < BUF_DEPTH, oREAD SHALL pulse high for exactly one cycle and the FSM SHALL enter WAIT_Q; otherwise it SHALL remain in IDLE with oREAD=0.
REQ-018 iADDRESS SHALL be treated as valid in the cycle after oREAD (normal-mode FIFO) and latched in WAIT_Q.
REQ-019 In WAIT_Q with bit 19=1, the FSM SHALL drive oSRAM_ADDR, assert oSRAM_OE_N=0, load the wait counter with SRAM_WAIT and enter READ.
REQ-020 In WAIT_Q with bit 19=0, the FSM SHALL push the invalid colour into the buffer without accessing SRAM and return to IDLE.
REQ-021 In READ, oSRAM_ADDR and oSRAM_OE_N=0 SHALL be held stable; on counter expiry iSRAM_DQ SHALL be pushed into the buffer and the FSM SHALL return to IDLE with oSRAM_OE_N=1.
REQ-022 Minimum address-to-pixel latency SHALL be 2+SRAM_WAIT cycles from oREAD for valid addresses and 2 cycles for invalid addresses.
REQ-023 Pixel order out SHALL equal address order popped; at most one access SHALL be in flight.
REQ-024 The in-flight slot SHALL be reserved at oREAD so that a push never finds the buffer full.
REQ-025 iDISP_REQ with oPIXEL_VALID=1 SHALL pop the head in that cycle; simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-026 iDISP_REQ with oPIXEL_VALID=0 SHALL set oUNDERRUN, leave buffer state unchanged and keep oPIXEL at its last value.
REQ-027 Buffer read/write pointers SHALL wrap modulo BUF_DEPTH.
REQ-028 oREAD SHALL never be asserted while iREADY_N=1.

Reset
REQ-029 RESET_N=0 SHALL immediately force FSM=IDLE, oREAD=0, oSRAM_OE_N=1, oSRAM_ADDR=0, oPIXEL=0, oPIXEL_VALID=0, oUNDERRUN=0, pointers/count/wait counter=0.
REQ-030 Reset during WAIT_Q or READ SHALL discard the in-flight address and pixel; no push SHALL occur after release until a new oREAD.
REQ-031 oUNDERRUN SHALL clear only on reset.

Configuration
REQ-032 With PIXEL_FETCH_BORDER_EN defined, invalid addresses SHALL yield BORDER_COLOUR; undefined, they SHALL yield 16'h0000 and BORDER_COLOUR SHALL be unused.

Verification
REQ-033 FIFO word 20'h80005 ready, SRAM_WAIT=1, SRAM returns 16'hABCD -> oREAD one pulse, oSRAM_ADDR=20'h00005, oPIXEL=16'hABCD valid 3 cycles after oREAD.
REQ-034 Word 20'h00000 (invalid) -> no oSRAM_OE_N assertion; oPIXEL=16'h001F with macro, 16'h0000 without, 2 cycles after oREAD.
REQ-035 Continuous addresses, iDISP_REQ=0 -> exactly 4 pixels buffered, oREAD stops; one iDISP_REQ -> exactly one further oREAD.
REQ-036 iDISP_REQ=1 with empty buffer -> oUNDERRUN=1 persists until RESET_N=0.
REQ-037 RESET_N pulsed low during READ -> oSRAM_OE_N=1 same cycle, oPIXEL_VALID=0, no stale pixel after release.
REQ-038 Full buffer, simultaneous push and pop for 16 cycles -> count stays 4, pixel order matches address order across pointer wrap.

Source files
------------

// File: rtl/pixel_fetch_if.sv
// pixel_fetch_if: groups the address-FIFO, SRAM and display-side signals
// of the pixel fetch engine. The master modport is the fetch engine
// itself; the slave modport is the surrounding system (FIFO, SRAM, display).
interface pixel_fetch_if;
  logic [19:0] iADDRESS;
  logic        iREADY_N;
  logic        oREAD;
  logic [19:0] oSRAM_ADDR;
  logic        oSRAM_OE_N;
  logic [15:0] iSRAM_DQ;
  logic        iDISP_REQ;
  logic [15:0] oPIXEL;
  logic        oPIXEL_VALID;
  logic        oUNDERRUN;

  modport master (
    input  iADDRESS, iREADY_N, iSRAM_DQ, iDISP_REQ,
    output oREAD, oSRAM_ADDR, oSRAM_OE_N, oPIXEL, oPIXEL_VALID, oUNDERRUN
  );

  modport slave (
    output iADDRESS, iREADY_N, iSRAM_DQ, iDISP_REQ,
    input  oREAD, oSRAM_ADDR, oSRAM_OE_N, oPIXEL, oPIXEL_VALID, oUNDERRUN
  );
endinterface

// File: rtl/pixel_fetch.sv
// pixel_fetch: pops pixel addresses from a normal-mode address FIFO, reads
// each valid address from an asynchronous SRAM (SRAM_WAIT cycles of OE),
// and queues the pixels in a small show-ahead buffer for the display.
// Invalid addresses (bit 19 clear) skip the SRAM and push an invalid colour.
// Optional feature: define PIXEL_FETCH_BORDER_EN to make invalid addresses
// yield BORDER_COLOUR instead of black.
module pixel_fetch #(
  parameter int          SRAM_WAIT     = 1,
  parameter int          BUF_DEPTH     = 4,
  parameter logic [15:0] BORDER_COLOUR = 16'h001F
) (
  input  logic          CLK,
  input  logic          RESET_N,
  pixel_fetch_if.master bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

`ifdef PIXEL_FETCH_BORDER_EN
  localparam logic [15:0] INVALID_COLOUR = BORDER_COLOUR;
`else
  // Border feature off: the border colour is masked away, invalid pixels are black.
  localparam logic [15:0] INVALID_COLOUR = BORDER_COLOUR & 16'h0000;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_Q = 2'd1,
    READ   = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [2:0]       wait_r, wait_nxt_s;
  logic [19:0]      sram_addr_r, sram_addr_nxt_s;
  logic             oe_n_r, oe_n_nxt_s;
  logic             inflight_r, inflight_nxt_s;
  logic             rd_req_s;
  logic             push_s;
  logic [15:0]      push_data_s;

  logic [15:0]      mem_r [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_nxt_s, rd_ptr_inc_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [15:0]      pixel_r, pixel_nxt_s;
  logic             valid_r;
  logic             underrun_r;
  logic             pop_s;

  // Fetch FSM next state: the in-flight slot is reserved at the FIFO read so a push always fits.
  always_comb begin
    state_nxt_s     = state_r;
    wait_nxt_s      = wait_r;
    sram_addr_nxt_s = sram_addr_r;
    oe_n_nxt_s      = oe_n_r;
    inflight_nxt_s  = inflight_r;
    rd_req_s        = 1'b0;
    push_s          = 1'b0;
    push_data_s     = 16'h0000;
    case (state_r)
      IDLE: begin
        if (!bus.iREADY_N &&
            ((count_r + {{(CNT_W-1){1'b0}}, inflight_r}) < DEPTH_C)) begin
          rd_req_s       = 1'b1;
          inflight_nxt_s = 1'b1;
          state_nxt_s    = WAIT_Q;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      WAIT_Q: begin
        if (bus.iADDRESS[19]) begin
          sram_addr_nxt_s = {1'b0, bus.iADDRESS[18:0]};
          oe_n_nxt_s      = 1'b0;
          wait_nxt_s      = 3'(SRAM_WAIT);
          state_nxt_s     = READ;
        end else begin
          push_s          = 1'b1;
          push_data_s     = INVALID_COLOUR;
          inflight_nxt_s  = 1'b0;
          state_nxt_s     = IDLE;
        end
      end
      READ: begin
        if (wait_r <= 3'd1) begin
          push_s         = 1'b1;
          push_data_s    = bus.iSRAM_DQ;
          oe_n_nxt_s     = 1'b1;
          inflight_nxt_s = 1'b0;
          wait_nxt_s     = 3'd0;
          state_nxt_s    = IDLE;
        end else begin
          wait_nxt_s     = wait_r - 3'd1;
        end
      end
      default: begin
        oe_n_nxt_s     = 1'b1;
        inflight_nxt_s = 1'b0;
        wait_nxt_s     = 3'd0;
        state_nxt_s    = IDLE;
      end
    endcase
  end

  // Fetch FSM state, SRAM address/OE and wait counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= IDLE;
      wait_r      <= 3'd0;
      sram_addr_r <= 20'h00000;
      oe_n_r      <= 1'b1;
      inflight_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wait_r      <= wait_nxt_s;
      sram_addr_r <= sram_addr_nxt_s;
      oe_n_r      <= oe_n_nxt_s;
      inflight_r  <= inflight_nxt_s;
    end
  end

  // Buffer bookkeeping: pointers, occupancy and the next show-ahead head pixel.
  always_comb begin
    pop_s        = bus.iDISP_REQ & valid_r;
    rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
    wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
    rd_ptr_nxt_s = pop_s ? rd_ptr_inc_s : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    pixel_nxt_s = pixel_r;
    if (pop_s) begin
      if (count_nxt_s == CNT_W'(0)) begin
        pixel_nxt_s = pixel_r;
      end else if (push_s && (wr_ptr_r == rd_ptr_inc_s)) begin
        pixel_nxt_s = push_data_s;
      end else begin
        pixel_nxt_s = mem_r[rd_ptr_inc_s];
      end
    end else if (push_s && (count_r == CNT_W'(0))) begin
      pixel_nxt_s = push_data_s;
    end else begin
      pixel_nxt_s = pixel_r;
    end
  end

  // Pixel storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Buffer pointers, count, head pixel, valid flag and sticky underrun.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      pixel_r    <= 16'h0000;
      valid_r    <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      pixel_r    <= pixel_nxt_s;
      valid_r    <= (count_nxt_s != CNT_W'(0));
      underrun_r <= underrun_r | (bus.iDISP_REQ & ~valid_r);
    end
  end

  // The FIFO read strobe must fall in the same cycle as IDLE is left, so it is
  // decoded from the state register; reset masks it immediately.
  assign bus.oREAD        = rd_req_s & RESET_N;
  assign bus.oSRAM_ADDR   = sram_addr_r;
  assign bus.oSRAM_OE_N   = oe_n_r;
  assign bus.oPIXEL       = pixel_r;
  assign bus.oPIXEL_VALID = valid_r;
  assign bus.oUNDERRUN    = underrun_r;

endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: directed self-checking bench for pixel_fetch with default
// parameters (SRAM_WAIT=1, BUF_DEPTH=4). A normal-mode address FIFO model
// and an SRAM model (data = address[15:0] ^ 16'hABC8) surround the DUT.
module tb_pixel_fetch;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [19:0] addr_q[$];
  logic [15:0] exp_px[$];
  logic        pend;

  pixel_fetch_if bus();

  pixel_fetch dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.master)
  );

  always #5 CLK = ~CLK;

  // SRAM model: asynchronous read while OE is low.
  assign bus.iSRAM_DQ = bus.oSRAM_OE_N ? 16'h0000 : (bus.oSRAM_ADDR[15:0] ^ 16'hABC8);

  // Normal-mode address FIFO model: word appears in the cycle after oREAD.
  initial begin
    bus.iADDRESS = 20'h00000;
    bus.iREADY_N = 1'b1;
    forever begin
      @(negedge CLK);
      pend = bus.oREAD;
      @(posedge CLK);
      #1;
      if (pend && addr_q.size() > 0) bus.iADDRESS = addr_q.pop_front();
      bus.iREADY_N = (addr_q.size() == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    while (bus.oREAD !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(bus.oREAD), 32'h1);
  endtask

  initial begin
    int rd_cnt;
    int pops;
    int vcnt;
    logic [31:0] border_exp;
`ifdef PIXEL_FETCH_BORDER_EN
    border_exp = 32'h001F;
`else
    border_exp = 32'h0000;
`endif
    bus.iDISP_REQ = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_read",  32'(bus.oREAD),        32'h0);
    chk("rst_oe_n",  32'(bus.oSRAM_OE_N),   32'h1);
    chk("rst_addr",  32'(bus.oSRAM_ADDR),   32'h0);
    chk("rst_pixel", 32'(bus.oPIXEL),       32'h0);
    chk("rst_valid", 32'(bus.oPIXEL_VALID), 32'h0);
    chk("rst_undr",  32'(bus.oUNDERRUN),    32'h0);
    RESET_N = 1'b1;

    // Valid address 0x5: SRAM returns 0xABCD, pixel 3 cycles after oREAD
    addr_q.push_back(20'h80005);
    wait_rd("v_read");
    @(negedge CLK);
    chk("v_read_pulse", 32'(bus.oREAD),        32'h0);
    chk("v_oe_early",   32'(bus.oSRAM_OE_N),   32'h1);
    chk("v_valid_c1",   32'(bus.oPIXEL_VALID), 32'h0);
    @(negedge CLK);
    chk("v_oe",         32'(bus.oSRAM_OE_N),   32'h0);
    chk("v_addr",       32'(bus.oSRAM_ADDR),   32'h00005);
    chk("v_valid_c2",   32'(bus.oPIXEL_VALID), 32'h0);
    @(negedge CLK);
    chk("v_valid",      32'(bus.oPIXEL_VALID), 32'h1);
    chk("v_pixel",      32'(bus.oPIXEL),       32'hABCD);
    chk("v_oe_off",     32'(bus.oSRAM_OE_N),   32'h1);
    bus.iDISP_REQ = 1'b1;
    @(negedge CLK);
    bus.iDISP_REQ = 1'b0;
    chk("pop_empty",    32'(bus.oPIXEL_VALID), 32'h0);
    chk("pop_hold",     32'(bus.oPIXEL),       32'hABCD);

    // Invalid address: no SRAM access, invalid colour 2 cycles after oREAD
    addr_q.push_back(20'h00000);
    wait_rd("i_read");
    @(negedge CLK);
    chk("i_oe_c1",      32'(bus.oSRAM_OE_N),   32'h1);
    chk("i_valid_c1",   32'(bus.oPIXEL_VALID), 32'h0);
    @(negedge CLK);
    chk("i_oe_c2",      32'(bus.oSRAM_OE_N),   32'h1);
    chk("i_valid",      32'(bus.oPIXEL_VALID), 32'h1);
    chk("i_pixel",      32'(bus.oPIXEL),       border_exp);
    bus.iDISP_REQ = 1'b1;
    @(negedge CLK);
    bus.iDISP_REQ = 1'b0;

    // Continuous addresses, no display: exactly 4 reads then stall
    for (int i = 0; i < 6; i++) addr_q.push_back(20'h80010 + 20'(i));
    rd_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus.oREAD === 1'b1) rd_cnt++;
    end
    chk("fill_reads",  32'(rd_cnt),           32'd4);
    chk("fill_valid",  32'(bus.oPIXEL_VALID), 32'h1);
    chk("fill_head",   32'(bus.oPIXEL),       32'hABD8);
    chk("fill_q_left", 32'(addr_q.size()),    32'd2);
    bus.iDISP_REQ = 1'b1;
    @(negedge CLK);
    bus.iDISP_REQ = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.oREAD === 1'b1) rd_cnt++;
      @(negedge CLK);
    end
    chk("one_more_read", 32'(rd_cnt),      32'd1);
    chk("head_after",    32'(bus.oPIXEL),  32'hABD9);
    chk("no_undr_yet",   32'(bus.oUNDERRUN), 32'h0);

    // Push+pop together across pointer wrap: pop in every SRAM data cycle
    exp_px.push_back(16'hABD9);
    exp_px.push_back(16'hABDA);
    exp_px.push_back(16'hABDB);
    exp_px.push_back(16'hABDC);
    exp_px.push_back(16'hABDD);
    for (int i = 0; i < 15; i++) begin
      addr_q.push_back(20'h80020 + 20'(i));
      exp_px.push_back(16'hABE8 ^ 16'(i));
    end
    pops = 0;
    vcnt = 0;
    for (int n = 0; n < 300 && pops < 17; n++) begin
      @(negedge CLK);
      bus.iDISP_REQ = 1'b0;
      if (bus.oPIXEL_VALID !== 1'b1) vcnt++;
      if (pops == 0 || bus.oSRAM_OE_N === 1'b0) begin
        chk("wrap_px", 32'(bus.oPIXEL), 32'(exp_px.pop_front()));
        bus.iDISP_REQ = 1'b1;
        pops++;
      end
    end
    chk("wrap_pops",   32'(pops), 32'd17);
    chk("wrap_nonempty", 32'(vcnt), 32'd0);
    for (int n = 0; n < 30 && exp_px.size() > 0; n++) begin
      @(negedge CLK);
      bus.iDISP_REQ = 1'b0;
      if (bus.oPIXEL_VALID === 1'b1) begin
        chk("drain_px", 32'(bus.oPIXEL), 32'(exp_px.pop_front()));
        bus.iDISP_REQ = 1'b1;
      end
    end
    @(negedge CLK);
    bus.iDISP_REQ = 1'b0;
    chk("drain_done",  32'(exp_px.size()),    32'd0);
    chk("drain_empty", 32'(bus.oPIXEL_VALID), 32'h0);

    // Underrun: request with empty buffer
    bus.iDISP_REQ = 1'b1;
    @(negedge CLK);
    bus.iDISP_REQ = 1'b0;
    chk("undr_set",   32'(bus.oUNDERRUN),    32'h1);
    chk("undr_hold",  32'(bus.oPIXEL),       32'hABE6);
    chk("undr_valid", 32'(bus.oPIXEL_VALID), 32'h0);
    repeat (5) @(negedge CLK);
    chk("undr_sticky", 32'(bus.oUNDERRUN), 32'h1);

    // Reset in READ: OE released at once, no stale pixel afterwards
    addr_q.push_back(20'h80007);
    wait_rd("r_read");
    @(negedge CLK);
    @(negedge CLK);
    chk("r_oe_on",    32'(bus.oSRAM_OE_N), 32'h0);
    chk("r_undr_pre", 32'(bus.oUNDERRUN),  32'h1);
    RESET_N = 1'b0;
    #1;
    chk("r_oe_off",   32'(bus.oSRAM_OE_N),   32'h1);
    chk("r_addr",     32'(bus.oSRAM_ADDR),   32'h0);
    chk("r_valid",    32'(bus.oPIXEL_VALID), 32'h0);
    chk("r_undr_clr", 32'(bus.oUNDERRUN),    32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    vcnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.oPIXEL_VALID !== 1'b0) vcnt++;
      if (bus.oREAD !== 1'b0) rd_cnt++;
    end
    chk("r_no_stale", 32'(vcnt),   32'd0);
    chk("r_no_read",  32'(rd_cnt), 32'd0);

    // Recovery after reset: fresh fetch of address 0x9
    addr_q.push_back(20'h80009);
    wait_rd("rec_read");
    repeat (3) @(negedge CLK);
    chk("rec_valid", 32'(bus.oPIXEL_VALID), 32'h1);
    chk("rec_pixel", 32'(bus.oPIXEL),       32'hABC1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
